// File: rtl/digit_scanner.sv
// digit_scanner: eight-digit hex display memory with a multiplexed scan.
// Holds 8x4-bit digit values and steps a 3-bit digit index through 0..7,
// one slot every CLK_DIV cycles, presenting the selected digit, its
// seven-segment pattern and a blanking strobe for the start of each slot.
//
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   enable          - scan enable; low freezes the scan and blanks the display
//   clear           - synchronous clear of all digit registers (beats wr_en)
//   wr_en/addr/data - digit write port
//   number          - current digit index (to the 3-to-8 select decoder)
//   digit           - stored value of digit `number`
//   seg             - active-high segment pattern for `digit`, seg[0]=a..seg[6]=g
//   blank           - high while all digit selects must be off
//   frame_tick      - one-cycle pulse when the index wraps 7 -> 0
module digit_scanner #(
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       clear,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic [2:0] number,
    output logic [3:0] digit,
    output logic [6:0] seg,
    output logic       blank,
    output logic       frame_tick
);

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned INDEX_W    = 3;
    localparam int unsigned PRESC_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);
    localparam logic [PRESC_W-1:0] BLANK_END = PRESC_W'(BLANK_CYCLES);

    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] mem_q, mem_d;
    logic [PRESC_W-1:0]                 presc_q, presc_d;
    logic [INDEX_W-1:0]                 number_q, number_d;
    logic                               frame_tick_q, frame_tick_d;

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q        <= '0;
            presc_q      <= '0;
            number_q     <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            presc_q      <= presc_d;
            number_q     <= number_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Digit memory update; clear wins over a same-cycle write
    always_comb begin
        mem_d = mem_q;
        if (clear) begin
            mem_d = '0;
        end else if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Prescaler and digit index; both hold while enable is low
    always_comb begin
        presc_d      = presc_q;
        number_d     = number_q;
        frame_tick_d = 1'b0;
        if (enable) begin
            if (presc_q == PRESC_MAX) begin
                presc_d      = '0;
                number_d     = number_q + INDEX_W'(1);
                // Pulse lands in the first cycle the index reads 0 again
                frame_tick_d = (number_q == INDEX_W'(NUM_DIGITS - 1));
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end
    end

    // Hex to seven-segment decode of the displayed digit
    always_comb begin
        digit = mem_q[number_q];
        unique case (digit)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
    end

    assign number     = number_q;
    assign blank      = ~enable | (presc_q < BLANK_END);
    assign frame_tick = frame_tick_q;

endmodule

// File: doc/digit_scanner.md
# digit_scanner

Digit memory and multiplex scan controller for the 8-digit seven-segment display. Holds eight 4-bit digit values and steps a 3-bit digit index through 0..7 at a programmable rate. The index drives the downstream 3-to-8 digit-select decoder's `number` input. The block also presents the hex segment pattern for the selected digit, plus a blanking strobe that suppresses ghosting at digit changes.

## Interface

Parameters:
- `CLK_DIV`, default 50000: clock cycles per digit slot. Legal range is at least 2.
- `BLANK_CYCLES`, default 4: cycles at the start of each slot during which `blank` is high. Legal range is 1 ≤ `BLANK_CYCLES` < `CLK_DIV`.

Ports:
- `clk` input, 1: single clock, rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `enable` input, 1: scan enable. When low, the scan freezes and the display blanks.
- `clear` input, 1: synchronous clear of all eight digit registers.
- `wr_en` input, 1: digit write strobe.
- `wr_addr` input, 3: digit index to write.
- `wr_data` input, 4: hex value to write.
- `number` output, 3: current digit index. Feeds the decoder `number` input.
- `digit` output, 4: stored value of digit `number`.
- `seg` output, 7: segment pattern for `digit`, active high. `seg[0]`=a … `seg[6]`=g.
- `blank` output, 1: high means all digit selects must be off.
- `frame_tick` output, 1: one-cycle pulse at the start of each full scan frame.

## Operation

Digit memory:
- 8×4 registers; all reset to 0.
- When `clear` is high, all eight registers go to 0 at the next edge.
- When `wr_en` is high and `clear` is low, the register at `wr_addr` takes `wr_data` at the next edge.
- `clear` has priority over a simultaneous `wr_en`.
- Writes are accepted regardless of `enable`.
- `digit` is a combinational read of mem[`number`]. A write to the displayed index appears on `digit`/`seg` in the cycle after the write edge.

Scan:
- The prescaler `presc` counts 0..`CLK_DIV`−1 while `enable` is high.
- At `presc` = `CLK_DIV`−1, `presc` returns to 0 and `number` increments, wrapping 7→0.
- When `enable` is low, `presc` and `number` hold their values. Counting resumes from the held values when `enable` returns high; no restart.
- `blank` = ~`enable` | (`presc` < `BLANK_CYCLES`). This is combinational from registered `presc`.
- `frame_tick` is a registered pulse, high for the one cycle in which `number` first equals 0 after a 7→0 wrap. It is never asserted by reset alone.

Segment decode (`seg`, hex, combinational from `digit`):
- 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07
- 8→7F, 9→6F, A→77, b→7C, C→39, d→5E, E→79, F→71

## Timing

Reset (`rst_n` low, asynchronous, at any time including mid-slot or mid-write):
- `presc`=0, `number`=0, all digits 0, `frame_tick`=0.
- Hence `digit`=0, `seg`=3F, `blank`=1.
- A write on the same edge as reset release is ignored only if `rst_n` is still low at that edge.

Slot timing with `enable` held high:
- Each slot lasts exactly `CLK_DIV` cycles.
- `blank` is high for the first `BLANK_CYCLES` of each slot.
- A full frame is 8×`CLK_DIV` cycles.
- `frame_tick` period is 8×`CLK_DIV` cycles.
- The first `frame_tick` after reset occurs 8×`CLK_DIV` cycles after the first enabled edge.

Latency:
- Write-to-display latency is 1 cycle.
- Change of `enable` reaches `blank` combinationally in the same cycle.

Boundary conditions:
- `enable` dropping exactly at `presc` = `CLK_DIV`−1: no increment on that edge.
- A write to index k while `number` steps to k on the same edge: the new value is shown one cycle later, never a stale value beyond that.

## Test plan

Bench uses `CLK_DIV`=8, `BLANK_CYCLES`=2.

1. Reset with `enable`=1 → `number`=0, `digit`=0, `seg`=3F, `blank`=1, `frame_tick`=0. After release, `blank` falls after 2 cycles. `number`=1 at cycle 8.
2. Free-run for 64 cycles after reset release → `number` sequence 0..7 in 8-cycle steps. `blank` is high for 2 of every 8 cycles. Exactly one `frame_tick` pulse, coincident with `number` returning to 0 at cycle 64.
3. Wait for `number`=3, then write `wr_addr`=3, `wr_data`=A → next cycle `digit`=A, `seg`=77. Writing address 5 with value 9, then waiting for `number`=5 → `seg`=6F.
4. Fill all digits with F, then assert `clear` together with `wr_en` (addr 2, data 7) → all digits read 0 on the following scan and `seg`=3F at every index.
5. Drop `enable` at `presc`=5 of slot 4 for 20 cycles → `number` stays 4, `blank`=1 throughout. After re-enable, `number` becomes 5 exactly 3 cycles later.
6. Assert `rst_n` low mid-slot 6 with digits loaded → outputs go immediately to the reset values and the digit memory reads all 0 after release.
